// File: rtl/ex_muldiv_pkg.sv
// Shared decode constants, FSM state type and operand-signedness helpers
// for the RV32M execution unit.
package ex_muldiv_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M      = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic op1_signed(input logic [2:0] funct3);
    return funct3 inside {INST_MUL, INST_MULH, INST_MULHSU, INST_DIV, INST_REM};
  endfunction

  function automatic logic op2_signed(input logic [2:0] funct3);
    return funct3 inside {INST_MUL, INST_MULH, INST_DIV, INST_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one bit per cycle; result ports carry the value after the current step.
module ex_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_div,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic                done,
  output logic [2*XLEN-1:0]   product,
  output logic [XLEN-1:0]     quotient,
  output logic [XLEN-1:0]     remainder
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]     count;
  logic              active;
  logic              is_div;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   divisor;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   quot_next;
  logic [XLEN-1:0]   rem_next;

  // Exposing next-step values lets the caller register the final result on the last step.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    trial    = {rem, quot[XLEN-1]};
    diff     = trial - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_next  = diff[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b1};
    end else begin
      rem_next  = trial[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b0};
    end
  end

  assign done      = active && (count == CW'(XLEN - 1));
  assign product   = acc_next;
  assign quotient  = quot_next;
  assign remainder = rem_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      active  <= 1'b0;
      is_div  <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
    end else if (start) begin
      count   <= '0;
      active  <= 1'b1;
      is_div  <= op_div;
      acc     <= '0;
      mcand   <= {{XLEN{1'b0}}, a};
      mplier  <= b;
      quot    <= a;
      rem     <= '0;
      divisor <= b;
    end else if (active) begin
      count <= count + CW'(1);
      if (done) begin
        active <= 1'b0;
      end
      if (is_div) begin
        quot <= quot_next;
        rem  <= rem_next;
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execution unit: accepts an M instruction from id_ex, holds the pipeline
// while the iterative datapath runs, then issues a one-cycle register writeback.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic            hold_flag_o,
  output logic            busy_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        funct3;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              s1_q;
  logic              s2_q;
  logic              is_m;
  logic              accept;
  logic              div_zero;
  logic              overflow;
  logic              special;
  logic              s1;
  logic              s2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [XLEN-1:0]   special_res;
  logic              iter_done;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quot_signed;
  logic [XLEN-1:0]   rem_signed;
  logic [XLEN-1:0]   final_res;
  logic              unused_inst;

  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

  assign funct3 = inst_i[14:12];
  assign is_m   = (inst_i[6:0] == INST_TYPE_R_M) && (inst_i[31:25] == FUNCT7_M) && reg_wen_i;
  assign accept = (state == IDLE) && is_m;

  assign s1   = op1_signed(funct3) & op1_i[XLEN-1];
  assign s2   = op2_signed(funct3) & op2_i[XLEN-1];
  assign mag1 = s1 ? -op1_i : op1_i;
  assign mag2 = s2 ? -op2_i : op2_i;

  // Zero divisor and signed MIN/-1 have fixed architectural results and skip the datapath.
  assign div_zero = funct3[2] && (op2_i == '0);
  assign overflow = funct3[2] && !funct3[0] && (op1_i == MOST_NEG) && (op2_i == '1);
  assign special  = div_zero || overflow;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? op1_i : '1;
    end else if (overflow) begin
      special_res = funct3[1] ? '0 : MOST_NEG;
    end
  end

  assign hold_flag_o = rst && (accept || (state == BUSY));
  assign busy_o      = (state != IDLE);

  ex_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && !special),
    .op_div    (funct3[2]),
    .a         (mag1),
    .b         (mag2),
    .done      (iter_done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Remainder takes the dividend's sign; product and quotient take the XOR of both.
  always_comb begin
    prod_signed = (s1_q ^ s2_q) ? -product : product;
    quot_signed = (s1_q ^ s2_q) ? -quotient : quotient;
    rem_signed  = s1_q ? -remainder : remainder;
    case (funct3_q)
      INST_MUL:                           final_res = prod_signed[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: final_res = prod_signed[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:                final_res = quot_signed;
      default:                            final_res = rem_signed;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      funct3_q  <= '0;
      rd_q      <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      rd_data_o <= '0;
      rd_addr_o <= '0;
      reg_wen_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_data_o <= '0;
          rd_addr_o <= '0;
          reg_wen_o <= 1'b0;
          if (is_m) begin
            funct3_q <= funct3;
            rd_q     <= rd_addr_i;
            s1_q     <= s1;
            s2_q     <= s2;
            if (special) begin
              state     <= DONE;
              rd_data_o <= special_res;
              rd_addr_o <= rd_addr_i;
              reg_wen_o <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (iter_done) begin
            state     <= DONE;
            rd_data_o <= final_res;
            rd_addr_o <= rd_q;
            reg_wen_o <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          rd_data_o <= '0;
          rd_addr_o <= '0;
          reg_wen_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: an arithmetic/latency model checked every cycle,
// plus literal result and latency expectations for each directed vector.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        reg_wen_i = 1'b0;
  logic        hold_flag_o;
  logic        busy_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int checks = 0;
  int errors = 0;

  int          wb_in = 0;
  logic        wb_now = 1'b0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_rd = '0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .reg_wen_i   (reg_wen_i),
    .hold_flag_o (hold_flag_o),
    .busy_o      (busy_o),
    .rd_data_o   (rd_data_o),
    .rd_addr_o   (rd_addr_o),
    .reg_wen_o   (reg_wen_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic is_m_inst(input logic [31:0] inst, input logic wen);
    return (inst[6:0] == 7'h33) && (inst[31:25] == 7'h01) && wen;
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Reference results from plain 64-bit arithmetic and the ISA's special-case table.
  function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    up = {32'b0, a} * {32'b0, b};
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: r = up[63:32];
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(ia / ib);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(ia % ib);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Latency model: 32 busy cycles then one writeback cycle, or writeback next cycle for special cases.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_in  = 0;
      wb_now = 1'b0;
      m_data = '0;
      m_rd   = '0;
    end else if (wb_now) begin
      wb_now = 1'b0;
    end else if (wb_in > 0) begin
      wb_in--;
      if (wb_in == 0) wb_now = 1'b1;
    end else if (is_m_inst(inst_i, reg_wen_i)) begin
      m_data = model_result(inst_i[14:12], op1_i, op2_i);
      m_rd   = rd_addr_i;
      if (is_special(inst_i[14:12], op1_i, op2_i)) wb_now = 1'b1;
      else wb_in = 32;
    end
  end

  always @(negedge clk) begin
    logic exp_hold;
    exp_hold = rst && ((wb_in > 0) || (!wb_now && is_m_inst(inst_i, reg_wen_i)));
    checkOutput("hold_flag", 32'(hold_flag_o), 32'(exp_hold));
    checkOutput("busy", 32'(busy_o), 32'((wb_in > 0) || wb_now));
    checkOutput("reg_wen", 32'(reg_wen_o), 32'(wb_now));
    checkOutput("rd_data", rd_data_o, wb_now ? m_data : 32'd0);
    checkOutput("rd_addr", 32'(rd_addr_o), wb_now ? 32'(m_rd) : 32'd0);
  end

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic wen);
    inst_i    = inst;
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = rd;
    reg_wen_i = wen;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_val, input int exp_lat);
    int lat;
    int hold_cnt;
    applyStimulus(mk_inst(7'h01, f3, rd), a, b, rd, 1'b1);
    hold_cnt = 0;
    @(negedge clk);
    if (hold_flag_o) hold_cnt++;
    @(posedge clk); #1;
    applyStimulus(32'h0000_0013, 32'd0, 32'd0, 5'd0, 1'b0);
    lat = 1;
    while (!reg_wen_o && lat < 100) begin
      @(negedge clk);
      if (hold_flag_o) hold_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, " data"}, rd_data_o, exp_val);
    checkOutput({name, " rd"}, 32'(rd_addr_o), 32'(rd));
    checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, " hold cycles"}, 32'(hold_cnt), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset hold", 32'(hold_flag_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset wen", 32'(reg_wen_o), 32'd0);
    checkOutput("reset data", rd_data_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFA, 5'd1, 32'hFFFF_FFD6, 33);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
    run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 33);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 33);
    run_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
    run_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run_op("DIVU", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    run_op("REMU", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);
    run_op("DIVU by 0", 3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    run_op("REM by 0", 3'd6, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);

    // Abort a multiply at busy count 10, then confirm a clean restart.
    applyStimulus(mk_inst(7'h01, 3'd0, 5'd9), 32'd100, 32'd3, 5'd9, 1'b1);
    @(posedge clk); #1;
    applyStimulus(32'h0000_0013, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort hold", 32'(hold_flag_o), 32'd0);
    checkOutput("abort busy", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_op("DIVU after reset", 3'd5, 32'd9, 32'd3, 5'd10, 32'd3, 33);

    applyStimulus(mk_inst(7'h00, 3'd0, 5'd17), 32'd1, 32'd2, 5'd17, 1'b1);
    @(negedge clk);
    checkOutput("ADD hold", 32'(hold_flag_o), 32'd0);
    @(posedge clk); #1;
    applyStimulus(mk_inst(7'h01, 3'd0, 5'd18), 32'd3, 32'd4, 5'd18, 1'b0);
    @(negedge clk);
    checkOutput("MUL nowen hold", 32'(hold_flag_o), 32'd0);
    @(posedge clk); #1;
    applyStimulus(32'h0000_0013, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("non-M wen", 32'(reg_wen_o), 32'd0);
      checkOutput("non-M busy", 32'(busy_o), 32'd0);
    end
    @(posedge clk); #1;

    applyStimulus(mk_inst(7'h01, 3'd5, 5'd11), 32'd5, 32'd0, 5'd11, 1'b1);
    @(posedge clk); #1;
    checkOutput("DONE wen", 32'(reg_wen_o), 32'd1);
    checkOutput("DONE data", rd_data_o, 32'hFFFF_FFFF);
    applyStimulus(mk_inst(7'h01, 3'd0, 5'd12), 32'd3, 32'd4, 5'd12, 1'b1);
    @(negedge clk);
    checkOutput("MUL in DONE hold", 32'(hold_flag_o), 32'd0);
    @(posedge clk); #1;
    run_op("MUL after DONE", 3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 33);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle RV32M execution unit in the EX stage.
- Consumes the id_ex register outputs: instruction, operands, rd address and write enable.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, one bit per cycle.
- While computing, it asserts a hold request to ctrl; when done, it drives a one-cycle register writeback.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the parameter exists for readability.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- inst_i  in  32  instruction from id_ex
- op1_i  in  32  rs1 value from id_ex
- op2_i  in  32  rs2 value from id_ex
- rd_addr_i  in  5  destination register from id_ex
- reg_wen_i  in  1  write enable from id_ex
- hold_flag_o  out  1  hold request to ctrl
- busy_o  out  1  unit not IDLE, for ctrl/EX output muxing
- rd_data_o  out  32  result
- rd_addr_o  out  5  destination register
- reg_wen_o  out  1  one-cycle writeback strobe

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0; internal registers 0.
  - Deassertion is synchronous to clk.
- M-instruction decode: opcode 7'b0110011, funct7 7'b0000001, reg_wen_i=1. funct3 selects the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If an M-instruction is present, the unit latches op1, op2, funct3, rd_addr and the operand signs, and asserts hold_flag_o combinationally in that same cycle.
  - Operands are latched because id_ex outputs a NOP bubble while held.
  - Normal operands go to BUSY with counter=0.
  - Special cases go to DONE directly (latency 1): divisor==0, or signed DIV/REM with 0x80000000 / 0xFFFFFFFF.
  - Non-M instructions: no action, outputs stay 0.
- BUSY:
  - 32 iterations, counter 0..31.
  - Multiply: shift-add on |op1|, |op2| (unsigned magnitudes) into a 64-bit accumulator.
  - Divide: restoring division on magnitudes. The 32-bit quotient and remainder shift registers are updated each cycle.
  - hold_flag_o=1 throughout. At counter==31, go to DONE.
- Sign handling:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats op1 as signed and op2 as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
  - Product/quotient sign = s1 XOR s2, applied by two's-complement negation in DONE.
  - Remainder sign = dividend sign.
- Result selection:
  - MUL returns product[31:0].
  - MULH/MULHSU/MULHU return product[63:32].
- DONE (exactly 1 cycle):
  - reg_wen_o=1, rd_addr_o=latched rd, rd_data_o=result. hold_flag_o=0.
  - Next state is IDLE; inst_i is ignored in DONE.
  - rd_data_o, rd_addr_o and reg_wen_o return to 0 the cycle after.
- Special results:
  - DIV/DIVU by 0: quotient 0xFFFFFFFF.
  - REM/REMU by 0: remainder = op1.
  - Signed overflow: DIV returns 0x80000000; REM returns 0.
- Latency from the accept cycle to the writeback cycle:
  - Normal operands: 33 cycles. hold_flag_o is high for 33 cycles (accept + 32 BUSY).
  - Special cases: 1 cycle.
- Back-to-back: the earliest acceptance of a second M-instruction is the cycle after DONE.
- Reset mid-operation aborts the operation: no writeback, state IDLE, hold_flag_o=0 immediately.
- busy_o = (state != IDLE).

Decomposition:
- defines.v gains INST_TYPE_R_M (7'b0110011), FUNCT7_M (7'b0000001) and the eight funct3 constants INST_MUL through INST_REMU.
- One sub-module, muldiv_iter, holds the iterative shift-add/restoring datapath plus the counter:
  - start and op-select in; done, 64-bit product, quotient and remainder out.
- The FSM, sign logic, special-case bypass and writeback stay in ex_muldiv.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFA (-6): hold_flag_o high 33 cycles, then one cycle reg_wen_o=1, rd_data_o=0xFFFFFFD6, rd_addr_o=latched rd.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each writes back 33 cycles after accept.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, DIV 0x80000000/-1 → 0x80000000, REM same → 0. All write back 1 cycle after accept, with hold_flag_o high only in the accept cycle.
- Drive rst=0 at BUSY counter=10, then release and present DIVU 9/3: no stale writeback; the new result 3 is produced 33 cycles after accept.
- ADD instruction (funct7=0) and a MUL with reg_wen_i=0: no hold, no writeback. A MUL presented during DONE is ignored; the same MUL re-presented the next cycle is accepted.
